ad7864_seq: RTL and testbench
=============================

# ad7864_seq

Parametrised conversion sequencer for one to four AD7864 ADCs sharing a conversion clock, in internal-clock mode. It sits between the DSP's conversion-request pin and the ADC control pins. One DSP request runs a full frame: conversion start, ADC clock burst, end-of-conversion wait, then readout of every channel of every chip. During readout, a per-word ready strobe tells the DSP when to latch the data bus. It supersedes the fixed-timing single-chip driver and adds multi-chip readout, end-of-conversion tracking and overrun detection.

## Interface
- NUM_CHIPS, 4: number of AD7864 devices (1..4)
- NUM_CH, 4: channels read per chip (1..4)
- CLK_HALF, 1: clkout half-period in clkin cycles (>=1)
- CONV_CLKS, 56: clkout rising edges per conversion burst
- CONV_LOW, 4: ad_conv_bar low width, clkin cycles
- RD_LOW, 3: ad_rd_bar low width per word (>=2)
- RD_GAP, 2: ad_rd_bar high time between words (>=1)
- TIMEOUT, 1024: busy-wait limit, clkin cycles (only with AD7864_SEQ_TIMEOUT_EN)
- clkin  in  1  system clock
- rst  in  1  synchronous, active-high reset
- dsp_conv_bar  in  1  asynchronous DSP frame request; a falling edge starts a frame
- ad_busy  in  1  OR of the ADC BUSY pins, active high, asynchronous
- clkout  out  1  conversion clock to all ADCs
- ad_conv_bar  out  1  CONVST, shared by all chips
- ad_cs_bar  out  NUM_CHIPS  per-chip chip select, active low
- ad_rd_bar  out  1  shared RD strobe
- db_rdy  out  1  data word valid on the ADC bus; DSP latches it
- word_idx  out  $clog2(NUM_CHIPS*NUM_CH) (min 1)  index of the current word, computed as chip*NUM_CH+ch
- seq_busy  out  1  high whenever the state is not IDLE
- frame_done  out  1  one-cycle pulse at the end of a frame
- overrun  out  1  sticky flag: a request arrived while a frame was running
- timeout_err  out  1  sticky flag (tied 0 without the macro)

## Operation
- Reset values: clkout 0; ad_conv_bar 1; ad_cs_bar all 1; ad_rd_bar 1; db_rdy 0; word_idx 0; seq_busy 0; frame_done 0; overrun 0; timeout_err 0; state IDLE; synchroniser flops reset to 1.
- dsp_conv_bar and ad_busy each pass through a 2-flop synchroniser. Start is a falling edge at the synchroniser output (prev 1, now 0).
- States and transitions:
  - IDLE, on start, goes to CONV.
  - CONV drives ad_conv_bar low for exactly CONV_LOW cycles, then goes to BURST.
  - BURST toggles clkout every CLK_HALF cycles, starting low, until CONV_CLKS rising edges have been emitted. It ends with clkout low and goes to WAITB.
  - WAITB waits for the synchronised ad_busy to be 0, then goes to READ.
  - READ issues NUM_CHIPS*NUM_CH words in order chip0 ch0..chN-1, then chip1, and so on. When the last word's gap completes it goes to DONE.
  - DONE lasts one cycle with frame_done=1, then goes to IDLE.
- READ detail:
  - ad_cs_bar[chip] is low for the whole span of that chip's words, including gaps.
  - Per word, ad_rd_bar is low for RD_LOW cycles, then high for RD_GAP cycles.
  - db_rdy is high only in the last cycle of each RD low window; word_idx is stable for that whole word.
- A start seen in any state other than IDLE is ignored and sets overrun. overrun clears on the next accepted start or on rst.
- A start and frame completion in the same cycle: DONE goes to IDLE, and the start is counted as an overrun.
- All counters saturate or reload; nothing wraps silently. word_idx returns to 0 in IDLE.
- rst in any state forces the reset values on the next clock; a partially read frame is discarded.

## Timing
- Start-detect latency is 2–3 clkin cycles after the dsp_conv_bar fall, due to synchronisation. ad_conv_bar falls 1 cycle after detect.
- BURST length is 2*CLK_HALF*CONV_CLKS cycles.
- READ length is NUM_CHIPS*NUM_CH*(RD_LOW+RD_GAP) cycles.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- AD7864_SEQ_TIMEOUT_EN defined:
  - A counter runs in WAITB. Reaching TIMEOUT cycles with busy still high aborts the frame to IDLE (no READ, no frame_done) and sets timeout_err.
  - timeout_err is sticky until rst.
- AD7864_SEQ_TIMEOUT_EN undefined: WAITB waits indefinitely, timeout_err is constant 0, and the counter is not built.

## Structure
- Package ad7864_pkg holds the state enum type and the width helper for word_idx.
- One sub-module, ad7864_sync2: a reusable 2-flop synchroniser with reset value 1. It is instantiated for dsp_conv_bar and ad_busy.

## Test plan
- Default parameters, a single request, ad_busy dropping 10 cycles after the burst: ad_conv_bar low for 4 cycles; 56 clkout pulses; 16 db_rdy pulses with word_idx 0..15 in order; each ad_cs_bar low for 4 words; frame_done pulses once.
- NUM_CHIPS=1, NUM_CH=2, CLK_HALF=2: the burst is 224 cycles; exactly 2 db_rdy pulses, 5 cycles apart.
- A second dsp_conv_bar fall during BURST: the frame completes unchanged and overrun=1. The next request is accepted and clears overrun.
- rst asserted mid-READ after word 5: all outputs return to reset values within 1 cycle, and a following request restarts at word_idx 0.
- AD7864_SEQ_TIMEOUT_EN defined with TIMEOUT=100 and ad_busy held high: after 100 WAITB cycles, timeout_err=1 and the sequencer returns to IDLE; no db_rdy and no frame_done.
- dsp_conv_bar held low through a whole frame: only one frame runs, with no retrigger until a new high-to-low edge.

Source files
------------

// File: rtl/ad7864_pkg.sv
// Shared types for the AD7864 conversion sequencer: FSM state encoding and index-width helper.
package ad7864_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_BURST,
        S_WAITB,
        S_READ,
        S_DONE
    } seq_state_t;

    // Width of an index over n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ad7864_seq_if.sv
// ADC-side pin bundle shared by all AD7864 devices on one sequencer.
interface ad7864_seq_if #(
    parameter int NUM_CHIPS = 4
);
    logic                 clkout;
    logic                 ad_conv_bar;
    logic [NUM_CHIPS-1:0] ad_cs_bar;
    logic                 ad_rd_bar;
    logic                 ad_busy;

    modport master (
        output clkout, ad_conv_bar, ad_cs_bar, ad_rd_bar,
        input  ad_busy
    );

    modport slave (
        input  clkout, ad_conv_bar, ad_cs_bar, ad_rd_bar,
        output ad_busy
    );
endinterface

// File: rtl/ad7864_sync2.sv
// Two-flop synchroniser for an asynchronous active-low level; both flops reset to 1.
// Latency 2 clkin cycles; no backpressure.
module ad7864_sync2 (
    input  logic clkin,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clkin) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/ad7864_seq.sv
// AD7864 frame sequencer: CONVST, clock burst, BUSY wait, multi-chip readout; all outputs registered.
// Start-to-CONVST 3-4 clkin cycles; no backpressure. AD7864_SEQ_TIMEOUT_EN adds the BUSY-wait abort.
module ad7864_seq
    import ad7864_pkg::*;
#(
    parameter int NUM_CHIPS = 4,
    parameter int NUM_CH    = 4,
    parameter int CLK_HALF  = 1,
    parameter int CONV_CLKS = 56,
    parameter int CONV_LOW  = 4,
    parameter int RD_LOW    = 3,
    parameter int RD_GAP    = 2,
    parameter int TIMEOUT   = 1024,
    localparam int IDX_W    = idx_w(NUM_CHIPS * NUM_CH)
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             dsp_conv_bar,
    ad7864_seq_if.master     adc,
    output logic             db_rdy,
    output logic [IDX_W-1:0] word_idx,
    output logic             seq_busy,
    output logic             frame_done,
    output logic             overrun,
    output logic             timeout_err
);
    localparam int M1     = (CONV_LOW > CLK_HALF) ? CONV_LOW : CLK_HALF;
    localparam int M2     = (M1 > RD_LOW + RD_GAP) ? M1 : RD_LOW + RD_GAP;
    localparam int M3     = (M2 > TIMEOUT) ? M2 : TIMEOUT;
    localparam int CNT_W  = $clog2(M3 + 1);
    localparam int ECNT_W = $clog2(CONV_CLKS + 1);
    localparam int CHIP_W = idx_w(NUM_CHIPS);
    localparam int CH_W   = idx_w(NUM_CH);

    localparam logic [CNT_W-1:0]  CONV_LAST = CNT_W'(CONV_LOW - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLK_HALF - 1);
    localparam logic [CNT_W-1:0]  RD_LOW_C  = CNT_W'(RD_LOW);
    localparam logic [CNT_W-1:0]  RDY_AT    = CNT_W'(RD_LOW - 1);
    localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(RD_LOW + RD_GAP - 1);
    localparam logic [ECNT_W-1:0] EDGES     = ECNT_W'(CONV_CLKS);
    localparam logic [CHIP_W-1:0] CHIP_LAST = CHIP_W'(NUM_CHIPS - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);

    seq_state_t           state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [ECNT_W-1:0]    edges, edges_nxt;
    logic [CHIP_W-1:0]    chip, chip_nxt;
    logic [CH_W-1:0]      ch, ch_nxt;
    logic                 clk_q, clk_nxt;
    logic                 conv_q, conv_nxt;
    logic [NUM_CHIPS-1:0] cs_q, cs_nxt;
    logic                 rd_q, rd_nxt;
    logic                 rdy_nxt, done_nxt, ovr_nxt;
    logic [IDX_W-1:0]     widx_nxt;
    logic                 conv_s, busy_s, conv_prev, start;

    ad7864_sync2 u_sync_conv (.clkin(clkin), .rst(rst), .d(dsp_conv_bar), .q(conv_s));
    ad7864_sync2 u_sync_busy (.clkin(clkin), .rst(rst), .d(adc.ad_busy),  .q(busy_s));

    assign start           = conv_prev & ~conv_s;
    assign adc.clkout      = clk_q;
    assign adc.ad_conv_bar = conv_q;
    assign adc.ad_cs_bar   = cs_q;
    assign adc.ad_rd_bar   = rd_q;

`ifdef AD7864_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    logic terr_q, terr_nxt;
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        edges_nxt = edges;
        chip_nxt  = chip;
        ch_nxt    = ch;
        clk_nxt   = clk_q;
        ovr_nxt   = overrun;
`ifdef AD7864_SEQ_TIMEOUT_EN
        terr_nxt  = terr_q;
`endif
        // A start accepted from IDLE clears the flag; one seen anywhere else sets it.
        if (start) ovr_nxt = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                cnt_nxt   = '0;
                edges_nxt = '0;
                chip_nxt  = '0;
                ch_nxt    = '0;
                clk_nxt   = 1'b0;
                if (start) state_nxt = S_CONV;
            end
            S_CONV: begin
                if (cnt == CONV_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_BURST;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_BURST: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt = '0;
                    clk_nxt = ~clk_q;
                    if (!clk_q) edges_nxt = edges + 1'b1;
                    else if (edges == EDGES) state_nxt = S_WAITB;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_WAITB: begin
                if (!busy_s) begin
                    cnt_nxt   = '0;
                    state_nxt = S_READ;
                end
`ifdef AD7864_SEQ_TIMEOUT_EN
                else if (cnt == TO_LAST) begin
                    state_nxt = S_IDLE;
                    terr_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
`endif
            end
            S_READ: begin
                if (cnt == WORD_LAST) begin
                    cnt_nxt = '0;
                    if (ch == CH_LAST) begin
                        ch_nxt = '0;
                        if (chip == CHIP_LAST) state_nxt = S_DONE;
                        else chip_nxt = chip + 1'b1;
                    end else begin
                        ch_nxt = ch + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Pin values are derived from the next state so every output leaves a flop.
        conv_nxt = (state_nxt != S_CONV);
        rd_nxt   = !((state_nxt == S_READ) && (cnt_nxt < RD_LOW_C));
        rdy_nxt  = (state_nxt == S_READ) && (cnt_nxt == RDY_AT);
        done_nxt = (state_nxt == S_DONE);
        for (int i = 0; i < NUM_CHIPS; i++)
            cs_nxt[i] = !((state_nxt == S_READ) && (chip_nxt == CHIP_W'(i)));
        widx_nxt = (state_nxt == S_READ) ?
                   IDX_W'(int'(chip_nxt) * NUM_CH + int'(ch_nxt)) : '0;
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            edges      <= '0;
            chip       <= '0;
            ch         <= '0;
            conv_prev  <= 1'b1;
            clk_q      <= 1'b0;
            conv_q     <= 1'b1;
            cs_q       <= '1;
            rd_q       <= 1'b1;
            db_rdy     <= 1'b0;
            word_idx   <= '0;
            seq_busy   <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            edges      <= edges_nxt;
            chip       <= chip_nxt;
            ch         <= ch_nxt;
            conv_prev  <= conv_s;
            clk_q      <= clk_nxt;
            conv_q     <= conv_nxt;
            cs_q       <= cs_nxt;
            rd_q       <= rd_nxt;
            db_rdy     <= rdy_nxt;
            word_idx   <= widx_nxt;
            seq_busy   <= (state_nxt != S_IDLE);
            frame_done <= done_nxt;
            overrun    <= ovr_nxt;
        end
    end

`ifdef AD7864_SEQ_TIMEOUT_EN
    always_ff @(posedge clkin) begin
        if (rst) terr_q <= 1'b0;
        else     terr_q <= terr_nxt;
    end
`endif
endmodule

// File: tb/tb_ad7864_seq.sv
// Bench for ad7864_seq: a default 4x4 instance under random frames, plus a 1-chip/2-channel instance.
`timescale 1ns/1ps
module tb_ad7864_seq;
    localparam int NC = 4, NH = 4, CH = 1, CC = 56, CL = 4, RL = 3, RG = 2, TO = 100;
    localparam int NW = NC * NH;

    logic clkin = 1'b0;
    always #5 clkin = ~clkin;

    logic       rst, a_dsp, b_dsp;
    logic       a_rdy, a_busy_o, a_done, a_ovr, a_terr;
    logic [3:0] a_idx;
    logic       b_rdy, b_busy_o, b_done, b_ovr, b_terr;
    logic [0:0] b_idx;

    ad7864_seq_if #(.NUM_CHIPS(NC)) a_if ();
    ad7864_seq_if #(.NUM_CHIPS(1))  b_if ();

    ad7864_seq #(.TIMEOUT(TO)) u_dut_a (
        .clkin(clkin), .rst(rst), .dsp_conv_bar(a_dsp), .adc(a_if),
        .db_rdy(a_rdy), .word_idx(a_idx), .seq_busy(a_busy_o),
        .frame_done(a_done), .overrun(a_ovr), .timeout_err(a_terr)
    );

    ad7864_seq #(.NUM_CHIPS(1), .NUM_CH(2), .CLK_HALF(2)) u_dut_b (
        .clkin(clkin), .rst(rst), .dsp_conv_bar(b_dsp), .adc(b_if),
        .db_rdy(b_rdy), .word_idx(b_idx), .seq_busy(b_busy_o),
        .frame_done(b_done), .overrun(b_ovr), .timeout_err(b_terr)
    );

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Frame-level reference for instance A: accumulate what the pins did, compare at frame end.
    int m_cyc = 0, m_lo, m_rises, m_tcr, m_tfall, m_tidle, m_idx, m_trdy, m_rdlo, m_frames = 0;
    bit p_conv = 1, p_clk = 0, p_rd = 1, p_busy = 0, p_done = 0;

    always @(negedge clkin) begin
        m_cyc++;
        if (rst) begin
            m_idx = 0; m_rises = 0; m_lo = 0; m_rdlo = 0;
        end else begin
            if (a_busy_o && !p_busy) begin
                m_idx = 0; m_rises = 0; m_lo = 0; m_rdlo = 0; m_tcr = 0; m_tfall = 0;
            end
            if (!a_busy_o && p_busy) m_tidle = m_cyc;
            if (!a_if.ad_conv_bar) m_lo++;
            if (a_if.ad_conv_bar && !p_conv) m_tcr = m_cyc;
            if (a_if.clkout && !p_clk) m_rises++;
            if (!a_if.clkout && p_clk) m_tfall = m_cyc;
            if (!a_if.ad_rd_bar) m_rdlo++;
            else if (!p_rd) begin
                chk("rd_low_width", m_rdlo, RL);
                m_rdlo = 0;
            end
            if (a_rdy) begin
                chk("word_idx", a_idx, m_idx);
                chk("cs_bar", a_if.ad_cs_bar, ((1 << NC) - 1) & ~(1 << (m_idx / NH)));
                chk("rd_at_rdy", a_if.ad_rd_bar, 0);
                if (m_idx > 0) chk("rdy_gap", m_cyc - m_trdy, RL + RG);
                m_trdy = m_cyc;
                m_idx++;
            end
            if (a_done) begin
                chk("done_pulse_width", p_done, 0);
                chk("conv_low", m_lo, CL);
                chk("clk_pulses", m_rises, CC);
                chk("burst_len", m_tfall - m_tcr, 2 * CH * CC);
                chk("words", m_idx, NW);
                m_frames++;
            end
        end
        p_conv = a_if.ad_conv_bar; p_clk = a_if.clkout; p_rd = a_if.ad_rd_bar;
        p_busy = a_busy_o; p_done = a_done;
    end

    // Instance B: 1 chip, 2 channels, CLK_HALF=2 -> 224-cycle burst, 2 words 5 cycles apart.
    int b_cyc = 0, b_tcr, b_tfall, b_trdy, b_words, b_frames = 0;
    bit q_conv = 1, q_clk = 0, q_busy = 0;

    always @(negedge clkin) begin
        b_cyc++;
        if (!rst) begin
            if (b_busy_o && !q_busy) b_words = 0;
            if (b_if.ad_conv_bar && !q_conv) b_tcr = b_cyc;
            if (!b_if.clkout && q_clk) b_tfall = b_cyc;
            if (b_rdy) begin
                chk("b_word_idx", b_idx, b_words);
                if (b_words > 0) chk("b_rdy_gap", b_cyc - b_trdy, 5);
                b_trdy = b_cyc;
                b_words++;
            end
            if (b_done) begin
                chk("b_burst_len", b_tfall - b_tcr, 224);
                chk("b_words", b_words, 2);
                b_frames++;
            end
        end
        q_conv = b_if.ad_conv_bar; q_clk = b_if.clkout; q_busy = b_busy_o;
    end

    // ADC model for A: BUSY rises with CONVST, falls busy_dly cycles after the burst's last fall.
    int busy_dly = 10, drop_cnt = -1, adc_rises = 0;
    bit hold_busy = 0, adc_pclk = 0;

    initial begin
        a_if.ad_busy = 1'b0;
        forever begin
            @(negedge clkin);
            if (rst || !a_busy_o) begin
                a_if.ad_busy = 1'b0;
                drop_cnt = -1;
            end
            if (!rst) begin
                if (!a_if.ad_conv_bar) begin
                    a_if.ad_busy = 1'b1; adc_rises = 0; drop_cnt = -1;
                end
                if (a_if.clkout && !adc_pclk) adc_rises++;
                if (!a_if.clkout && adc_pclk && adc_rises == CC) drop_cnt = busy_dly;
                if (drop_cnt == 0 && !hold_busy) a_if.ad_busy = 1'b0;
                if (drop_cnt >= 0) drop_cnt--;
            end
            adc_pclk = a_if.clkout;
        end
    end

    task automatic wait_idle_a();
        for (int i = 0; i < 5000; i++) begin
            @(negedge clkin);
            if (!a_busy_o) break;
        end
        chk("idle_wait", a_busy_o, 0);
    endtask

    task automatic request_a(input bit hold);
        int lat = 0;
        wait_idle_a();
        @(posedge clkin); #1 a_dsp = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clkin);
            lat++;
            if (!a_if.ad_conv_bar) break;
        end
        chk("start_latency_in_3_4", (lat >= 3 && lat <= 4), 1);
        if (!hold) begin
            @(posedge clkin); #1 a_dsp = 1'b1;
        end
    endtask

    task automatic pulse_a();
        @(posedge clkin); #1 a_dsp = 1'b0;
        repeat (2) @(posedge clkin);
        #1 a_dsp = 1'b1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_clkout", a_if.clkout, 0);
        chk("rst_conv_bar", a_if.ad_conv_bar, 1);
        chk("rst_cs_bar", a_if.ad_cs_bar, 4'hF);
        chk("rst_rd_bar", a_if.ad_rd_bar, 1);
        chk("rst_db_rdy", a_rdy, 0);
        chk("rst_word_idx", a_idx, 0);
        chk("rst_seq_busy", a_busy_o, 0);
        chk("rst_frame_done", a_done, 0);
        chk("rst_overrun", a_ovr, 0);
        chk("rst_timeout_err", a_terr, 0);
    endtask

    initial begin
        int f0, r;
        bit inj;
        rst = 1'b1; a_dsp = 1'b1; b_dsp = 1'b1; b_if.ad_busy = 1'b0;
        repeat (4) @(posedge clkin);
        @(negedge clkin);
        chk_reset_outputs();
        @(posedge clkin); #1 rst = 1'b0;

        // Single frame, BUSY drops 10 cycles after the burst.
        f0 = m_frames;
        request_a(0);
        wait_idle_a();
        chk("frame_count", m_frames - f0, 1);
        chk("overrun_clean", a_ovr, 0);
        chk("idx_idle", a_idx, 0);

        // Reduced instance B.
        @(posedge clkin); #1 b_dsp = 1'b0;
        for (int i = 0; i < 2000 && b_frames == 0; i++) @(negedge clkin);
        chk("b_frames", b_frames, 1);
        #1 b_dsp = 1'b1;

        // Second request during the burst: frame unchanged, overrun set, then cleared.
        f0 = m_frames;
        request_a(0);
        for (int i = 0; i < 500 && m_rises < 10; i++) @(negedge clkin);
        chk("burst_reached", (m_rises >= 10), 1);
        pulse_a();
        wait_idle_a();
        chk("ovr_frame_count", m_frames - f0, 1);
        chk("overrun_set", a_ovr, 1);
        request_a(0);
        chk("overrun_cleared", a_ovr, 0);
        wait_idle_a();

        // Reset in the middle of READ, after word 5.
        request_a(0);
        for (int i = 0; i < 2000 && m_idx < 6; i++) @(negedge clkin);
        chk("read_reached", m_idx, 6);
        f0 = m_frames;
        @(posedge clkin); #1 rst = 1'b1;
        @(posedge clkin);
        @(negedge clkin);
        chk_reset_outputs();
        chk("rst_no_frame", m_frames - f0, 0);
        @(posedge clkin); #1 rst = 1'b0;
        request_a(0);
        wait_idle_a();
        chk("post_rst_frame", m_frames - f0, 1);

        // dsp_conv_bar held low through and past a frame: exactly one frame.
        f0 = m_frames;
        request_a(1);
        wait_idle_a();
        repeat (50) @(negedge clkin);
        chk("held_busy", a_busy_o, 0);
        chk("held_frames", m_frames - f0, 1);
        chk("held_overrun", a_ovr, 0);
        @(posedge clkin); #1 a_dsp = 1'b1;

`ifdef AD7864_SEQ_TIMEOUT_EN
        hold_busy = 1;
        f0 = m_frames;
        request_a(0);
        wait_idle_a();
        chk("timeout_err_set", a_terr, 1);
        chk("timeout_no_frame", m_frames - f0, 0);
        chk("timeout_no_words", m_idx, 0);
        chk("waitb_cycles", m_tidle - m_tfall, TO);
        hold_busy = 0;
        repeat (5) @(negedge clkin);
`else
        chk("timeout_err_tied", a_terr, 0);
`endif

        // Random frames: random gaps, BUSY delays and overrun injection.
        for (int k = 0; k < 12; k++) begin
            busy_dly = $urandom_range(0, 20);
            repeat ($urandom_range(0, 30)) @(posedge clkin);
            f0 = m_frames;
            request_a(0);
            inj = 1'($urandom_range(0, 1));
            if (inj) begin
                r = $urandom_range(0, 150);
                repeat (r) @(negedge clkin);
                if (a_busy_o && m_idx < NW - 3) pulse_a();
                else inj = 0;
            end
            wait_idle_a();
            chk("rnd_frames", m_frames - f0, 1);
            chk("rnd_overrun", a_ovr, inj);
            chk("rnd_idx_idle", a_idx, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1);
    end
endmodule
